// File: rtl/rs_decoder_pkg.sv
// Shared definitions for the RS decoder output path.
// Provides the output-stage state encoding and the last-address helper.
package rs_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } out_state_t;

  // Index of the final symbol issued per block (data only, or full codeword).
  function automatic int unsigned last_idx(input int unsigned blk_len,
                                           input int unsigned data_len,
                                           input int unsigned strip_parity);
    return (strip_parity != 0) ? (data_len - 1) : (blk_len - 1);
  endfunction

endpackage

// File: rtl/rs_ce_gen.sv
// Output pacing divider: one-clk CE pulse every CE_DIV clocks, plus CEO = CE delayed 1 clk.
// Ports:
//   clk   in   rising-edge clock
//   reset in   asynchronous active-high reset
//   CE    out  registered pacing pulse (high when the counter was CE_DIV-1)
//   CEO   out  CE delayed by one clock
module rs_ce_gen #(
  parameter int unsigned CE_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  output logic CE,
  output logic CEO
);

  localparam int unsigned CNT_W = $clog2(CE_DIV);

  logic [CNT_W-1:0] cnt;

  // Free-running counter; wraps naturally since CE_DIV is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      CE  <= 1'b0;
      CEO <= 1'b0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      CE  <= (cnt == CNT_W'(CE_DIV - 1));
      CEO <= CE;
    end
  end

endmodule

// File: rtl/rs_out_stage_p.sv
// RS decoder output stage: reads a decoded block from ping-pong memories and
// emits corrected symbols at one per CE_DIV clocks, with one block of lookahead.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   DONE      in   one-clk pulse, a decoded block is ready
//   RE        out  bank select, toggles per accepted block
//   RdAdd     out  read address into the selected bank
//   In_byte   in   stored symbol at RdAdd (1 clk latency)
//   Err_val   in   error magnitude at RdAdd (1 clk latency)
//   Out_byte  out  corrected symbol
//   CEO       out  output clock enable
//   Valid_out out  Out_byte belongs to an active block
//   out_done  out  one-clk pulse after the last symbol of a block
//   busy      out  a block is armed or running
//   overrun   out  sticky, a DONE was lost
module rs_out_stage_p
  import rs_decoder_pkg::*;
#(
  parameter int unsigned SYM_W        = 8,
  parameter int unsigned BLK_LEN      = 204,
  parameter int unsigned DATA_LEN     = 188,
  parameter int unsigned CE_DIV       = 8,
  parameter int unsigned STRIP_PARITY = 1,
  parameter int unsigned CORR_EN      = 1,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DONE,
  output logic              RE,
  output logic [ADDR_W-1:0] RdAdd,
  input  logic [SYM_W-1:0]  In_byte,
  input  logic [SYM_W-1:0]  Err_val,
  output logic [SYM_W-1:0]  Out_byte,
  output logic              CEO,
  output logic              Valid_out,
  output logic              out_done,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned LAST = last_idx(BLK_LEN, DATA_LEN, STRIP_PARITY);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST);

  out_state_t        state, state_n;
  logic [ADDR_W-1:0] rd_n;
  logic [SYM_W-1:0]  ob_n;
  logic              re_n, vo_n, od_n, pend, pend_n, ovr_n, busy_n;
  logic              ce;
  logic [SYM_W-1:0]  sym_c;
  logic              last_ce_c;

  rs_ce_gen #(.CE_DIV(CE_DIV)) u_ce_gen (
    .clk   (clk),
    .reset (reset),
    .CE    (ce),
    .CEO   (CEO)
  );

  assign sym_c     = (CORR_EN != 0) ? (In_byte ^ Err_val) : In_byte;
  assign last_ce_c = ce && (RdAdd == LAST_A);

  // Next-state and output logic.
  always_comb begin
    state_n = state;
    rd_n    = RdAdd;
    re_n    = RE;
    ob_n    = Out_byte;
    vo_n    = Valid_out;
    od_n    = 1'b0;
    pend_n  = pend;
    ovr_n   = overrun;

    unique case (state)
      ST_IDLE: begin
        if (DONE) begin
          re_n    = ~RE;
          rd_n    = '0;
          state_n = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (ce) state_n = ST_RUN;
        if (DONE) begin
          if (pend) ovr_n  = 1'b1;
          else      pend_n = 1'b1;
        end
      end
      ST_RUN: begin
        // A DONE on the final CE is absorbed by the restart below.
        if (DONE && !last_ce_c) begin
          if (pend) ovr_n  = 1'b1;
          else      pend_n = 1'b1;
        end
        if (ce) begin
          ob_n = sym_c;
          vo_n = 1'b1;
          if (RdAdd == LAST_A) begin
            od_n = 1'b1;
            if (pend || DONE) begin
              re_n    = ~RE;
              rd_n    = '0;
              pend_n  = pend && DONE;
              state_n = ST_ARMED;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            rd_n = RdAdd + ADDR_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Any CE outside RUN issues nothing, which ends the valid window.
    if (ce && (state != ST_RUN)) vo_n = 1'b0;

    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      RdAdd     <= '0;
      RE        <= 1'b0;
      Out_byte  <= '0;
      Valid_out <= 1'b0;
      out_done  <= 1'b0;
      pend      <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      RdAdd     <= rd_n;
      RE        <= re_n;
      Out_byte  <= ob_n;
      Valid_out <= vo_n;
      out_done  <= od_n;
      pend      <= pend_n;
      overrun   <= ovr_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_rs_out_stage_p.sv
// Testbench for rs_out_stage_p: two instances (default parameters, and
// CE_DIV=2 / full codeword / no correction) against a block-level model.
module tb_rs_out_stage_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       done   [2];
  logic       re     [2];
  logic [7:0] rdadd  [2];
  logic [7:0] in_b   [2];
  logic [7:0] err_v  [2];
  logic [7:0] out_b  [2];
  logic       ceo    [2];
  logic       vo     [2];
  logic       od     [2];
  logic       busy   [2];
  logic       ovr    [2];

  logic [7:0] mem  [2][2][256];
  logic [7:0] emem [2][2][256];

  rs_out_stage_p u_dut0 (
    .clk(clk), .reset(reset), .DONE(done[0]), .RE(re[0]), .RdAdd(rdadd[0]),
    .In_byte(in_b[0]), .Err_val(err_v[0]), .Out_byte(out_b[0]), .CEO(ceo[0]),
    .Valid_out(vo[0]), .out_done(od[0]), .busy(busy[0]), .overrun(ovr[0])
  );

  rs_out_stage_p #(.CE_DIV(2), .STRIP_PARITY(0), .CORR_EN(0)) u_dut1 (
    .clk(clk), .reset(reset), .DONE(done[1]), .RE(re[1]), .RdAdd(rdadd[1]),
    .In_byte(in_b[1]), .Err_val(err_v[1]), .Out_byte(out_b[1]), .CEO(ceo[1]),
    .Valid_out(vo[1]), .out_done(od[1]), .busy(busy[1]), .overrun(ovr[1])
  );

  // Synchronous-read memories: data appears one clock after the address.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      in_b[d]  <= mem[d][re[d]][rdadd[d]];
      err_v[d] <= emem[d][re[d]][rdadd[d]];
    end
  end

  // Per-instance configuration.
  int lastv [2] = '{187, 203};
  int cdiv  [2] = '{8, 2};
  int corr  [2] = '{1, 0};

  // Block-level model state.
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         inflight [2];
  int         nsym     [2];
  int         last_cap [2];
  int         od_cnt   [2];
  bit         exp_re   [2];
  bit         exp_ovr  [2];
  bit         after_od [2];
  bit         prev_od  [2];
  bit         prev_vo  [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] capbuf [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void qpush(input int d, input logic [7:0] v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // A block starting flips the bank and queues its expected symbols.
  function automatic void start_block(input int d);
    exp_re[d] = ~exp_re[d];
    for (int a = 0; a <= lastv[d]; a++) begin
      if (corr[d] != 0) qpush(d, mem[d][exp_re[d]][a] ^ emem[d][exp_re[d]][a]);
      else              qpush(d, mem[d][exp_re[d]][a]);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      inflight[d] = 0; nsym[d] = 0; last_cap[d] = 0; od_cnt[d] = 0;
      exp_re[d] = 1'b0; exp_ovr[d] = 1'b0; after_od[d] = 1'b0;
      prev_od[d] = 1'b0; prev_vo[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endfunction

  // One clock: observe both instances at the falling edge and advance the model.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (ceo[d] && after_od[d]) begin
        chk("valid_clear", 32'(vo[d]), 32'(0));
        after_od[d] = 1'b0;
      end
      if (!ceo[d]) chk("valid_hold", 32'(vo[d]), 32'(prev_vo[d]));
      prev_vo[d] = vo[d];
      if (ceo[d] && vo[d]) begin
        chk("sym_expected", 32'(qsize(d) > 0), 32'(1));
        if (qsize(d) > 0) begin
          e = qpop(d);
          chk($sformatf("sym%0d_%0d", d, nsym[d]), 32'(out_b[d]), 32'(e));
        end
        if (nsym[d] > 0) chk("spacing", 32'(cyc - last_cap[d]), 32'(cdiv[d]));
        if (d == 0 && nsym[d] < 256) capbuf[nsym[d]] = out_b[d];
        last_cap[d] = cyc;
        nsym[d]++;
      end
      if (od[d]) begin
        chk("od_width", 32'(prev_od[d]), 32'(0));
        chk("block_len", 32'(nsym[d]), 32'(lastv[d] + 1));
        nsym[d] = 0;
        od_cnt[d]++;
        after_od[d] = 1'b1;
        if (inflight[d] > 0) inflight[d]--;
        if (inflight[d] > 0) start_block(d);
      end
      prev_od[d] = od[d];
      if (done[d]) begin
        if (inflight[d] >= 2) exp_ovr[d] = 1'b1;
        else begin
          inflight[d]++;
          if (inflight[d] == 1) start_block(d);
        end
      end
      chk("re", 32'(re[d]), 32'(exp_re[d]));
      chk("overrun", 32'(ovr[d]), 32'(exp_ovr[d]));
      chk("busy", 32'(busy[d]), 32'(inflight[d] > 0));
    end
  endtask

  task automatic pulse(input int d);
    done[d] = 1'b1;
    tick();
    done[d] = 1'b0;
  endtask

  task automatic wait_sym(input int d, input int n);
    int t = 0;
    while (nsym[d] != n && t < 4000) begin tick(); t++; end
    chk("wait_sym", 32'(nsym[d]), 32'(n));
  endtask

  task automatic wait_idle(input int d);
    int t = 0;
    while ((inflight[d] != 0 || qsize(d) != 0) && t < 8000) begin tick(); t++; end
    chk("wait_idle", 32'(inflight[d] + qsize(d)), 32'(0));
    repeat (2 * cdiv[d] + 2) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    done[0] = 1'b0;
    done[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 256; a++) begin
          mem[d][b][a]  = 8'(a);
          emem[d][b][a] = 8'h00;
        end
    emem[0][1][10] = 8'h5A;
    do_reset();

    // Reset state.
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdadd", 32'(rdadd[d]), 32'(0));
      chk("rst_out", 32'(out_b[d]), 32'(0));
      chk("rst_valid", 32'(vo[d]), 32'(0));
      chk("rst_done", 32'(od[d]), 32'(0));
      chk("rst_re", 32'(re[d]), 32'(0));
    end

    // Directed block: memory[i]=i, one error at address 10.
    repeat (5) tick();
    pulse(0);
    wait_idle(0);
    chk("dir_sym10", 32'(capbuf[10]), 32'(8'h50));
    chk("dir_sym9", 32'(capbuf[9]), 32'(8'h09));
    chk("dir_sym187", 32'(capbuf[187]), 32'(8'd187));
    chk("dir_od_cnt", 32'(od_cnt[0]), 32'(1));
    chk("dir_re", 32'(re[0]), 32'(1));
    chk("dir_ovr", 32'(ovr[0]), 32'(0));

    // Random memory contents from here on.
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 256; a++) begin
          mem[d][b][a]  = 8'($urandom);
          emem[d][b][a] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        end

    // Lookahead: second DONE at symbol 100, third (lost) at symbol 150.
    od_cnt[0] = 0;
    pulse(0);
    wait_sym(0, 100);
    pulse(0);
    wait_sym(0, 150);
    pulse(0);
    wait_idle(0);
    chk("la_od_cnt", 32'(od_cnt[0]), 32'(2));
    chk("la_ovr", 32'(ovr[0]), 32'(1));
    chk("la_re", 32'(re[0]), 32'(1));

    // Reset mid-block, then restart.
    pulse(0);
    wait_sym(0, 50);
    do_reset();
    chk("mr_ovr", 32'(ovr[0]), 32'(0));
    chk("mr_valid", 32'(vo[0]), 32'(0));
    repeat (7) tick();
    pulse(0);
    wait_sym(0, 1);
    chk("mr_re", 32'(re[0]), 32'(1));
    wait_idle(0);
    chk("mr_od_cnt", 32'(od_cnt[0]), 32'(1));

    // Full codeword at CE_DIV=2, DONE coincident with the final CE.
    pulse(1);
    wait_sym(1, 203);
    tick();
    pulse(1);
    chk("co_od_cnt", 32'(od_cnt[1]), 32'(1));
    chk("co_busy", 32'(busy[1]), 32'(1));
    wait_idle(1);
    chk("co_od_cnt2", 32'(od_cnt[1]), 32'(2));
    chk("co_ovr", 32'(ovr[1]), 32'(0));

    // Random DONE timing on both instances.
    for (int k = 0; k < 6; k++) begin
      pulse(1);
      repeat ($urandom_range(1, 500)) tick();
    end
    wait_idle(1);
    for (int k = 0; k < 3; k++) begin
      pulse(0);
      repeat ($urandom_range(1, 2500)) tick();
    end
    wait_idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_out_stage_p.md
RS_OUT_STAGE_P -- requirements
Module: rs_out_stage_p

Interface
REQ-001 Parameter SYM_W, default 8, symbol width in bits.
REQ-002 Parameter BLK_LEN, default 204, symbols per stored codeword.
REQ-003 Parameter DATA_LEN, default 188, data symbols per codeword.
REQ-004 Parameter CE_DIV, default 8, output pacing divisor; power of two, >= 2.
REQ-005 Parameter STRIP_PARITY, default 1; 1 emits DATA_LEN symbols, 0 emits BLK_LEN symbols.
REQ-006 Parameter CORR_EN, default 1; 1 XORs Err_val into each output symbol.
REQ-007 Parameter ADDR_W, default 8, read address width; 2**ADDR_W >= BLK_LEN.
REQ-008 clk  in  1  single clock; all logic on its rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 DONE  in  1  one-clk pulse: a decoded block is ready in the input memories.
REQ-011 RE  out  1  ping-pong bank select for the input memories; toggles once per accepted block.
REQ-012 RdAdd  out  ADDR_W  read address into the selected bank.
REQ-013 In_byte  in  SYM_W  stored symbol at RdAdd, valid 1 clk after RdAdd changes.
REQ-014 Err_val  in  SYM_W  error magnitude at RdAdd, same timing as In_byte; 0 means no error.
REQ-015 Out_byte  out  SYM_W  corrected output symbol.
REQ-016 CEO  out  1  output clock enable: internal CE delayed 1 clk.
REQ-017 Valid_out  out  1  Out_byte belongs to an active block.
REQ-018 out_done  out  1  one-clk pulse after the last symbol of a block is issued.
REQ-019 busy  out  1  high in ARMED or RUN.
REQ-020 overrun  out  1  sticky: a DONE was lost.

Function
REQ-021 Free-running counter, log2(CE_DIV) bits, increments every clk; CE is registered high for exactly 1 clk when the counter equals CE_DIV-1.
REQ-022 LAST = DATA_LEN-1 when STRIP_PARITY=1, else BLK_LEN-1.
REQ-023 States: IDLE, ARMED, RUN.
REQ-024 IDLE + DONE: toggle RE, RdAdd<=0, go to ARMED.
REQ-025 ARMED + CE: go to RUN; no symbol is issued on that CE.
REQ-026 RUN + CE: Out_byte<=In_byte^Err_val (CORR_EN=1) or In_byte (CORR_EN=0); Valid_out<=1; if RdAdd==LAST then out_done<=1 and exit RUN, else RdAdd<=RdAdd+1.
REQ-027 Exit from RUN: if pending is set, toggle RE, RdAdd<=0, clear pending, go to ARMED; otherwise go to IDLE with RdAdd held.
REQ-028 DONE while ARMED or RUN with pending clear: set pending.
REQ-029 DONE while pending is set: set overrun; the pending count stays at 1.
REQ-030 DONE coincident with the final CE of RUN: treated as pending, so the block starts at once (REQ-027).
REQ-031 Valid_out clears on the first CE in which no symbol is issued; Out_byte holds its value.
REQ-032 out_done is high for exactly 1 clk per block.
REQ-033 Symbols are issued at one per CE_DIV clks; per block, exactly LAST+1 symbols are issued at addresses 0..LAST in order.

Reset
REQ-034 Reset clears RE, RdAdd, Out_byte, Valid_out, out_done, CEO, the internal CE, the counter, pending and overrun, and sets the state to IDLE.
REQ-035 Reset asserted mid-block abandons the block; the first DONE after release starts from address 0 with RE=1.

Structure
REQ-036 The state encoding and the LAST computation live in the shared rs_decoder_pkg.
REQ-037 The CE divider is the sub-module rs_ce_gen, parameterised by CE_DIV, with outputs CE and CEO.

Verification
REQ-038 Defaults, one DONE, Err_val=0, memory[i]=i: 188 Valid_out symbols 0..187, one every 8 clks; out_done pulses once; RE=1.
REQ-039 Err_val=8'h5A at address 10 only: symbol 10 = 8'h0A^8'h5A = 8'h50; all other symbols unchanged.
REQ-040 STRIP_PARITY=0: 204 symbols issued, last address 203.
REQ-041 Second DONE at symbol 100, third DONE at symbol 150: the second block follows with no IDLE gap, RE toggles twice in total, overrun=1.
REQ-042 Reset at symbol 50, then a new DONE: output restarts at address 0, overrun=0, Valid_out low until the first issued symbol.
REQ-043 CE_DIV=2, DONE coincident with the final CE: no lost block, out_done is a single 1-clk pulse.
